// File: rtl/crossyroad_lanes.sv
// Crossy-road lane engine: scrolling obstacle lanes, chicken row/score/lives FSM,
// pixel-level collision detection and a registered colour for the current scan position.
module crossyroad_lanes #(
  parameter int unsigned NUM_LANES   = 3,
  parameter int unsigned LANE_HEIGHT = 40,
  parameter int unsigned OBS_WIDTH   = 50,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned HIT_FRAMES  = 30,
  parameter int unsigned OB_X_OFFSET = 250
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_move,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  input  logic       i_display_on,
  input  logic       i_frame_tick,
  output logic [2:0] o_rgb,
  output logic [6:0] o_score,
  output logic [2:0] o_lives,
  output logic [1:0] o_state,
  output logic       o_collision
);

  localparam int unsigned X_W      = 10;
  localparam int unsigned ROW_W    = 4;
  localparam int unsigned FC_W     = ($clog2(HIT_FRAMES + 1) < 3) ? 3 : $clog2(HIT_FRAMES + 1);
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned ROW0_Y   = 80;
  localparam int unsigned INSET    = 5;
  localparam int unsigned CHICK_X0 = 310;
  localparam int unsigned CHICK_X1 = 340;
  localparam int unsigned SCORE_MAX = 99;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_HIT  = 2'b10,
    ST_OVER = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       score_q, score_d;
  logic [2:0]       lives_q, lives_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic             move_prev_q, move_prev_d;
  logic [2:0]       rgb_q, rgb_d;
  logic             coll_q, coll_d;
  logic [X_W-1:0]   obs_x_q [NUM_LANES];
  logic [X_W-1:0]   obs_x_d [NUM_LANES];

  logic             move_edge;
  logic [X_W-1:0]   speed;
  logic [15:0]      chick_top;
  logic             chick_hit;
  logic             obs_hit;
  logic             coll_now;

  function automatic logic in_row(input logic [15:0] y, input logic [15:0] top);
    return (y >= top + 16'(INSET)) && (y < top + 16'(LANE_HEIGHT) - 16'(INSET));
  endfunction

  // Distance from an obstacle's left edge to the scan x, wrapping across the right edge.
  function automatic logic [15:0] x_dist(input logic [X_W-1:0] h, input logic [X_W-1:0] x0);
    if (h >= x0) return 16'(h) - 16'(x0);
    else         return 16'(h) + 16'(SCREEN_W) - 16'(x0);
  endfunction

  function automatic logic [X_W-1:0] wrap_add(input logic [X_W-1:0] x, input logic [X_W-1:0] s);
    logic [X_W:0] t;
    t = {1'b0, x} + {1'b0, s};
    if (t >= (X_W+1)'(SCREEN_W)) t = t - (X_W+1)'(SCREEN_W);
    return X_W'(t);
  endfunction

  function automatic logic [X_W-1:0] wrap_sub(input logic [X_W-1:0] x, input logic [X_W-1:0] s);
    logic [X_W:0] t;
    if (x >= s) t = {1'b0, x} - {1'b0, s};
    else        t = {1'b0, x} + (X_W+1)'(SCREEN_W) - {1'b0, s};
    return X_W'(t);
  endfunction

  assign move_edge = i_move & ~move_prev_q;

  // Pixel coverage of the chicken and of any obstacle at the current scan position.
  always_comb begin : pixel_hits
    speed     = (score_q[6:3] >= 4'd3) ? X_W'(4) : X_W'(score_q[6:3]) + X_W'(1);
    chick_top = 16'(ROW0_Y) + 16'(row_q) * 16'(LANE_HEIGHT);
    chick_hit = (i_hpos >= 10'(CHICK_X0)) && (i_hpos < 10'(CHICK_X1)) &&
                in_row(16'(i_vpos), chick_top);
    obs_hit   = 1'b0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (in_row(16'(i_vpos), 16'(ROW0_Y + k * LANE_HEIGHT)) &&
          (x_dist(i_hpos, obs_x_q[k]) < 16'(OBS_WIDTH)))
        obs_hit = 1'b1;
    end
    coll_now = i_display_on & chick_hit & obs_hit;
  end

  always_comb begin : next_state
    state_d     = state_q;
    score_d     = score_q;
    lives_d     = lives_q;
    row_d       = row_q;
    fc_d        = fc_q;
    coll_d      = 1'b0;
    move_prev_d = i_move;
    obs_x_d     = obs_x_q;
    rgb_d       = 3'b000;

    unique case (state_q)
      ST_IDLE: if (move_edge) begin
        state_d = ST_PLAY;
        score_d = 7'd0;
        lives_d = 3'(LIVES);
        row_d   = ROW_W'(NUM_LANES);
      end
      ST_PLAY: begin
        // A collision in the same cycle as a move edge swallows the move.
        if (coll_now) begin
          coll_d  = 1'b1;
          lives_d = lives_q - 3'd1;
          row_d   = ROW_W'(NUM_LANES);
          fc_d    = '0;
          state_d = ST_HIT;
        end else if (move_edge) begin
          if (row_q != '0) begin
            row_d = row_q - ROW_W'(1);
          end else begin
            row_d = ROW_W'(NUM_LANES);
            if (score_q != 7'(SCORE_MAX)) score_d = score_q + 7'd1;
          end
        end
      end
      ST_HIT: if (i_frame_tick) begin
        if (fc_q == FC_W'(HIT_FRAMES - 1)) begin
          fc_d    = '0;
          state_d = (lives_q != 3'd0) ? ST_PLAY : ST_OVER;
        end else begin
          fc_d = fc_q + FC_W'(1);
        end
      end
      ST_OVER: if (move_edge) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (i_frame_tick && ((state_q == ST_PLAY) || (state_q == ST_HIT))) begin
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        obs_x_d[k] = ((k % 2) == 0) ? wrap_add(obs_x_q[k], speed) : wrap_sub(obs_x_q[k], speed);
      end
    end

    if (!i_display_on)          rgb_d = 3'b000;
    else if (chick_hit && obs_hit) rgb_d = 3'b011;
    else if (obs_hit)           rgb_d = 3'b100;
    else if (chick_hit)         rgb_d = ((state_q == ST_HIT) && fc_q[2]) ? 3'b011 : 3'b010;
    else                        rgb_d = (state_q == ST_OVER) ? 3'b101 : 3'b001;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      score_q     <= 7'd0;
      lives_q     <= 3'(LIVES);
      row_q       <= ROW_W'(NUM_LANES);
      fc_q        <= '0;
      move_prev_q <= 1'b0;
      rgb_q       <= 3'b000;
      coll_q      <= 1'b0;
      for (int unsigned k = 0; k < NUM_LANES; k++)
        obs_x_q[k] <= X_W'((k * OB_X_OFFSET) % SCREEN_W);
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      row_q       <= row_d;
      fc_q        <= fc_d;
      move_prev_q <= move_prev_d;
      rgb_q       <= rgb_d;
      coll_q      <= coll_d;
      obs_x_q     <= obs_x_d;
    end
  end

  assign o_rgb       = rgb_q;
  assign o_score     = score_q;
  assign o_lives     = lives_q;
  assign o_state     = state_q;
  assign o_collision = coll_q;

endmodule

// File: tb/tb_crossyroad_lanes.sv
// Scoreboard bench for crossyroad_lanes: pixel expectations are queued when a scan
// position is driven and compared against o_rgb one cycle later.
module tb_crossyroad_lanes;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_move = 1'b0;
  logic [9:0] i_hpos = '0;
  logic [9:0] i_vpos = '0;
  logic       i_display_on = 1'b0;
  logic       i_frame_tick = 1'b0;
  logic [2:0] o_rgb;
  logic [6:0] o_score;
  logic [2:0] o_lives;
  logic [1:0] o_state;
  logic       o_collision;

  int checks = 0;
  int errors = 0;
  int coll_cnt = 0;

  string      tag_q[$];
  logic [2:0] exp_q[$];

  // Bench model of obstacle positions and score (drives speed).
  int  xm [3];
  int  score_m = 0;
  bit  moving = 1'b0;

  crossyroad_lanes dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_move       (i_move),
    .i_hpos       (i_hpos),
    .i_vpos       (i_vpos),
    .i_display_on (i_display_on),
    .i_frame_tick (i_frame_tick),
    .o_rgb        (o_rgb),
    .o_score      (o_score),
    .o_lives      (o_lives),
    .o_state      (o_state),
    .o_collision  (o_collision)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_collision) coll_cnt++;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    string      t;
    logic [2:0] e;
    @(posedge i_clk);
    #1;
    if (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_eq(t, int'(o_rgb), int'(e));
    end
    i_display_on = 1'b0;
  endtask

  task automatic probe(input string tag, input int h, input int v, input int exp);
    i_hpos       = 10'(h);
    i_vpos       = 10'(v);
    i_display_on = 1'b1;
    tag_q.push_back(tag);
    exp_q.push_back(3'(exp));
    step();
  endtask

  task automatic press();
    i_move = 1'b1;
    step();
    i_move = 1'b0;
    step();
  endtask

  function automatic int spd();
    int s;
    s = score_m / 8;
    return (s >= 3) ? 4 : s + 1;
  endfunction

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      i_frame_tick = 1'b1;
      step();
      i_frame_tick = 1'b0;
      step();
      if (moving) begin
        xm[0] = (xm[0] + spd()) % 640;
        xm[1] = (xm[1] + 640 - spd()) % 640;
        xm[2] = (xm[2] + spd()) % 640;
      end
    end
  endtask

  // Advance frames until obstacle `lane` overlaps the chicken columns.
  task automatic park(input int lane);
    for (int i = 0; i < 700; i++) begin
      if (xm[lane] >= 265 && xm[lane] <= 335) break;
      frames(1);
    end
  endtask

  // Drive a pixel inside both the chicken (in row `lane`) and that lane's obstacle.
  task automatic hit_probe(input string tag, input int lane);
    int hp;
    hp = (xm[lane] > 310) ? xm[lane] : 310;
    probe(tag, hp, 100 + 40 * lane, 3);
  endtask

  initial begin
    #2 i_rst_n = 1'b0;
    repeat (3) step();
    check_eq("rst_state", int'(o_state), 0);
    check_eq("rst_score", int'(o_score), 0);
    check_eq("rst_lives", int'(o_lives), 3);
    check_eq("rst_rgb", int'(o_rgb), 0);
    check_eq("rst_coll", int'(o_collision), 0);
    i_rst_n = 1'b1;
    step();
    xm = '{0, 250, 500};

    // Start a game.
    press();
    moving = 1'b1;
    check_eq("start_state", int'(o_state), 1);
    check_eq("start_score", int'(o_score), 0);
    check_eq("start_lives", int'(o_lives), 3);
    probe("x0_lo", 0, 100, 4);
    probe("x0_hi", 49, 100, 4);
    probe("x0_end", 50, 100, 1);
    probe("x1", 250, 140, 4);
    probe("x1_pre", 249, 140, 1);
    probe("x2", 500, 180, 4);
    probe("x2_pre", 499, 180, 1);
    probe("chick", 320, 220, 2);
    probe("chick_edge", 309, 220, 1);

    // Obstacle motion and wrap.
    frames(10);
    probe("f10_x0", 10, 100, 4);
    probe("f10_x0_pre", 9, 100, 1);
    probe("f10_x1", 240, 140, 4);
    probe("f10_x1_pre", 239, 140, 1);
    probe("f10_x2", 510, 180, 4);
    probe("f10_x2_pre", 509, 180, 1);
    frames(625);
    probe("x0_635", 635, 100, 4);
    probe("x0_634", 634, 100, 1);
    frames(1);
    probe("wrap_636", 636, 100, 4);
    probe("wrap_639", 639, 100, 4);
    probe("wrap_0", 0, 100, 4);
    probe("wrap_45", 45, 100, 4);
    probe("wrap_46", 46, 100, 1);
    probe("wrap_635", 635, 100, 1);

    // Four moves cross the road once.
    repeat (4) press();
    score_m = 1;
    check_eq("cross_score", int'(o_score), 1);
    probe("cross_row3", 320, 220, 2);

    // A held button moves exactly once.
    i_move = 1'b1;
    repeat (100) step();
    i_move = 1'b0;
    step();
    probe("held_row2", 320, 180, 2);
    probe("held_row3", 320, 220, 1);
    check_eq("held_score", int'(o_score), 1);

    // First collision in lane 1.
    press();
    park(1);
    hit_probe("coll1_rgb", 1);
    step();
    check_eq("coll1_pulses", coll_cnt, 1);
    check_eq("coll1_lives", int'(o_lives), 2);
    check_eq("coll1_state", int'(o_state), 2);
    probe("hit_chick_row3", 320, 220, 2);
    press();
    frames(4);
    probe("hit_blink", 320, 220, 3);
    frames(25);
    check_eq("hit29_state", int'(o_state), 2);
    frames(1);
    check_eq("hit30_state", int'(o_state), 1);
    check_eq("hit_one_pulse", coll_cnt, 1);
    probe("after_hit_row3", 320, 220, 2);

    // Collision coinciding with a move edge.
    press();
    press();
    park(1);
    i_move = 1'b1;
    hit_probe("collmove_rgb", 1);
    i_move = 1'b0;
    step();
    check_eq("collmove_pulses", coll_cnt, 2);
    check_eq("collmove_lives", int'(o_lives), 1);
    check_eq("collmove_score", int'(o_score), 1);
    check_eq("collmove_state", int'(o_state), 2);
    probe("collmove_row3", 320, 220, 2);
    frames(30);
    check_eq("hit2_exit", int'(o_state), 1);

    // Final life lost -> game over.
    press();
    park(2);
    hit_probe("coll3_rgb", 2);
    step();
    check_eq("coll3_lives", int'(o_lives), 0);
    frames(30);
    moving = 1'b0;
    check_eq("over_state", int'(o_state), 3);
    check_eq("over_score", int'(o_score), 1);
    probe("over_bg", 320, 60, 5);
    frames(5);
    probe("over_frozen", xm[0], 100, 4);
    press();
    check_eq("idle_state", int'(o_state), 0);
    check_eq("idle_score_hold", int'(o_score), 1);
    check_eq("idle_lives_hold", int'(o_lives), 0);
    press();
    moving = 1'b1;
    score_m = 0;
    check_eq("restart_state", int'(o_state), 1);
    check_eq("restart_score", int'(o_score), 0);
    check_eq("restart_lives", int'(o_lives), 3);

    // Eight crossings raise speed to 2.
    repeat (32) press();
    score_m = 8;
    check_eq("score8", int'(o_score), 8);
    frames(1);
    probe("spd2_x0", xm[0], 100, 4);
    probe("spd2_x0_pre", (xm[0] + 639) % 640, 100, 1);

    // Reset asserted during HIT.
    press();
    park(2);
    hit_probe("coll4_rgb", 2);
    step();
    check_eq("coll4_state", int'(o_state), 2);
    i_rst_n = 1'b0;
    #1;
    check_eq("midrst_state", int'(o_state), 0);
    check_eq("midrst_lives", int'(o_lives), 3);
    check_eq("midrst_score", int'(o_score), 0);
    check_eq("midrst_coll", int'(o_collision), 0);
    step();
    i_rst_n = 1'b1;
    moving = 1'b0;
    step();
    step();
    check_eq("post_rst_state", int'(o_state), 0);
    check_eq("post_rst_pulses", coll_cnt, 4);
    probe("post_rst_x0", 0, 100, 4);
    probe("post_rst_x1", 250, 140, 4);
    probe("post_rst_x2", 500, 180, 4);
    probe("post_rst_chick", 320, 220, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
